pong_field_engine: RTL and testbench
====================================

Name: pong_field_engine

Overview:
- Parametrised game-state core for the two-player pong display path.
- Owns ball position and direction, two paddle positions, wall and paddle collisions, scoring and the serve/play/game-over sequencing.
- Updates only on a one-cycle frame_tick, which the video timing generator issues once per frame during vertical blanking.
- Its outputs feed the pixel renderer and the 7-segment score mux.

Parameters:
- H_RES, 640, visible width in pixels
- V_RES, 480, visible height in pixels
- XW, 10, width of x coordinates
- YW, 10, width of y coordinates
- BALL_SZ, 10, ball square side
- PAD_W, 10, paddle width
- PAD_H, 80, paddle height
- PAD_X_L, 16, left paddle left edge
- PAD_X_R, 614, right paddle left edge
- BALL_STEP, 2, ball pixels per tick per axis
- PAD_STEP, 4, paddle pixels per tick
- SERVE_FRAMES, 60, ticks held in SERVE before play
- WIN_SCORE, 9, winning score; must be ≤15

Ports:
- clk50  in  1  system clock
- reset  in  1  reset
- frame_tick  in  1  one-cycle pulse per frame
- start  in  1  restart request, pulse or level
- l_up  in  1  left paddle up
- l_dn  in  1  left paddle down
- r_up  in  1  right paddle up
- r_dn  in  1  right paddle down
- ball_x  out  XW  ball left edge
- ball_y  out  YW  ball top edge
- pad_l_y  out  YW  left paddle top
- pad_r_y  out  YW  right paddle top
- score_l  out  4  left score, binary
- score_r  out  4  right score, binary
- state  out  2  SERVE=0, PLAY=1, SCORED=2, GAMEOVER=3
- game_over  out  1  high in GAMEOVER
- hit_pulse  out  1  one clk50 cycle per paddle hit

Clocking and reset:
- One clock, clk50. reset is asynchronous and active-high.
- Reset values:
  - ball = ((H_RES-BALL_SZ)/2, (V_RES-BALL_SZ)/2) = (315,235)
  - pad_l_y = pad_r_y = (V_RES-PAD_H)/2 = 200
  - scores 0
  - state SERVE, serve_cnt 0
  - dir_x right, dir_y down
  - game_over 0, hit_pulse 0, start_pend 0
- Reset mid-game returns to these values immediately.

Behaviour:
- Timing:
  - All state changes happen only on clk50 edges where frame_tick=1.
  - Outputs reflect the new values from the following cycle (latency 1).
  - hit_pulse is high only in that cycle.
- start_pend:
  - Set on any cycle with start=1.
  - Cleared on every frame_tick.
  - Acted on only in GAMEOVER.
- Paddles (every state except GAMEOVER):
  - up & !dn: y = max(y-PAD_STEP, 0).
  - dn & !up: y = min(y+PAD_STEP, V_RES-PAD_H).
  - Both or neither: hold.
  - Saturation must not underflow the unsigned width.
- SERVE:
  - Ball held at centre; serve_cnt increments each tick.
  - At serve_cnt == SERVE_FRAMES-1: go to PLAY and clear serve_cnt.
- PLAY, vertical:
  - Down: if y+BALL_STEP ≥ V_RES-BALL_SZ, set y = V_RES-BALL_SZ and flip to up; else y += BALL_STEP.
  - Up: if y ≤ BALL_STEP, set y = 0 and flip to down; else y -= BALL_STEP.
- PLAY, horizontal left:
  - Face F = PAD_X_L+PAD_W.
  - Hit: x ≥ F, x-BALL_STEP < F, and overlap (y+BALL_SZ > pad_l_y && y < pad_l_y+PAD_H). Then x = F, dir right, hit_pulse.
  - Miss: else if x < BALL_STEP, score_r += 1, go to SCORED.
  - Otherwise x -= BALL_STEP.
- PLAY, horizontal right (mirror):
  - Face F = PAD_X_R-BALL_SZ; hit sets x = F and dir left.
  - Miss when x+BALL_STEP > H_RES-BALL_SZ; score_l += 1.
- Collision inputs: the overlap test uses the pre-tick y and pre-tick paddle registers.
- Simultaneous wall and paddle events on the same tick are both applied.
- SCORED (one tick):
  - Recentre the ball.
  - dir_x points toward the player who conceded; dir_y is kept.
  - If the incremented score == WIN_SCORE, go to GAMEOVER; else go to SERVE.
- GAMEOVER:
  - Ball, paddles and scores frozen; game_over = 1.
  - On a tick with start_pend: scores 0, paddles centred, ball centred, go to SERVE, game_over 0.
- Scores saturate at WIN_SCORE and never wrap.

Decomposition:
- pong_pkg holds:
  - state encoding constants
  - default geometry constants
  - centre-position localparams derived from them
- One sub-module, pong_paddle, instanced per side. It holds the saturating up/down mover with tick enable, freeze input and reset-to-centre.

Test Plan:
- Reset, 59 ticks → state SERVE, ball (315,235). Tick 60 → PLAY. Tick 61 → ball (317,237).
- Paddle limits:
  - l_up held 60 ticks → pad_l_y reaches 0 at tick 50 and stays 0.
  - r_dn held → 400.
  - l_up & l_dn together → unchanged.
- Bottom wall: play from reset with no paddle input → y climbs 2 per tick to 469, then clamps to 470 and flips. The next tick gives 468.
- Right hit: hold r_up/r_dn so pad_r_y covers ball_y at approach → ball_x clamps to 604, dir left, hit_pulse high exactly one cycle, scores unchanged.
- Right miss: pad_r_y driven to 0 with the ball low → score_l = 1, SCORED for one tick, then SERVE with the ball at centre and dir_x right.
- Win and restart:
  - Repeat misses to score_l = 9 → GAMEOVER, game_over = 1, outputs frozen over 10 ticks.
  - A 1-cycle start between ticks → next tick gives scores 0 and SERVE.
  - Assert reset mid-PLAY → reset values next cycle without a tick.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared definitions for the pong game-state core: state encoding,
// default geometry, derived centre positions and a score helper.
package pong_pkg;

    typedef enum logic [1:0] {
        ST_SERVE    = 2'd0,
        ST_PLAY     = 2'd1,
        ST_SCORED   = 2'd2,
        ST_GAMEOVER = 2'd3
    } state_t;

    localparam int DEF_H_RES        = 640;
    localparam int DEF_V_RES        = 480;
    localparam int DEF_XW           = 10;
    localparam int DEF_YW           = 10;
    localparam int DEF_BALL_SZ      = 10;
    localparam int DEF_PAD_W        = 10;
    localparam int DEF_PAD_H        = 80;
    localparam int DEF_PAD_X_L      = 16;
    localparam int DEF_PAD_X_R      = 614;
    localparam int DEF_BALL_STEP    = 2;
    localparam int DEF_PAD_STEP     = 4;
    localparam int DEF_SERVE_FRAMES = 60;
    localparam int DEF_WIN_SCORE    = 9;

    // Centre positions for the default geometry.
    localparam int BALL_X_CTR = (DEF_H_RES - DEF_BALL_SZ) / 2;
    localparam int BALL_Y_CTR = (DEF_V_RES - DEF_BALL_SZ) / 2;
    localparam int PAD_Y_CTR  = (DEF_V_RES - DEF_PAD_H) / 2;

    // Direction bit meanings.
    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;
    localparam logic DIR_UP    = 1'b0;
    localparam logic DIR_DOWN  = 1'b1;

    // Score increment that sticks at the winning value instead of wrapping.
    function automatic logic [3:0] sat_inc(input logic [3:0] s, input logic [3:0] lim);
        return (s >= lim) ? lim : s + 4'd1;
    endfunction

endpackage

// File: rtl/pong_paddle.sv
// One paddle: saturating up/down mover that only moves on a frame tick,
// can be frozen, and can be snapped back to the vertical centre.
module pong_paddle
    import pong_pkg::*;
#(
    parameter int YW       = DEF_YW,
    parameter int V_RES    = DEF_V_RES,
    parameter int PAD_H    = DEF_PAD_H,
    parameter int PAD_STEP = DEF_PAD_STEP
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_tick,
    input  logic          i_freeze,
    input  logic          i_recentre,
    input  logic          i_up,
    input  logic          i_dn,
    output logic [YW-1:0] o_y
);

    localparam logic [YW-1:0] Y_MAX  = YW'(V_RES - PAD_H);
    localparam logic [YW-1:0] Y_CTR  = YW'((V_RES - PAD_H) / 2);
    localparam logic [YW-1:0] Y_STEP = YW'(PAD_STEP);

    logic [YW-1:0] r_y;
    logic [YW-1:0] w_y_next;

    // Candidate position: compare before subtracting so the top never wraps.
    always_comb begin
        w_y_next = r_y;
        if (i_up && !i_dn) begin
            w_y_next = (r_y < Y_STEP) ? '0 : r_y - Y_STEP;
        end else if (i_dn && !i_up) begin
            w_y_next = (r_y > Y_MAX - Y_STEP) ? Y_MAX : r_y + Y_STEP;
        end
    end

    // Position register: recentre wins over freeze, both gated by the tick.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_y <= Y_CTR;
        end else if (i_tick) begin
            if (i_recentre) begin
                r_y <= Y_CTR;
            end else if (!i_freeze) begin
                r_y <= w_y_next;
            end
        end
    end

    assign o_y = r_y;

endmodule

// File: rtl/pong_field_engine.sv
// Pong game-state core: ball motion, wall/paddle collisions, scoring and
// serve/play/scored/game-over sequencing, advanced once per frame tick.
module pong_field_engine
    import pong_pkg::*;
#(
    parameter int H_RES        = DEF_H_RES,
    parameter int V_RES        = DEF_V_RES,
    parameter int XW           = DEF_XW,
    parameter int YW           = DEF_YW,
    parameter int BALL_SZ      = DEF_BALL_SZ,
    parameter int PAD_W        = DEF_PAD_W,
    parameter int PAD_H        = DEF_PAD_H,
    parameter int PAD_X_L      = DEF_PAD_X_L,
    parameter int PAD_X_R      = DEF_PAD_X_R,
    parameter int BALL_STEP    = DEF_BALL_STEP,
    parameter int PAD_STEP     = DEF_PAD_STEP,
    parameter int SERVE_FRAMES = DEF_SERVE_FRAMES,
    parameter int WIN_SCORE    = DEF_WIN_SCORE
) (
    input  logic          clk50,
    input  logic          reset,
    input  logic          frame_tick,
    input  logic          start,
    input  logic          l_up,
    input  logic          l_dn,
    input  logic          r_up,
    input  logic          r_dn,
    output logic [XW-1:0] ball_x,
    output logic [YW-1:0] ball_y,
    output logic [YW-1:0] pad_l_y,
    output logic [YW-1:0] pad_r_y,
    output logic [3:0]    score_l,
    output logic [3:0]    score_r,
    output logic [1:0]    state,
    output logic          game_over,
    output logic          hit_pulse
);

    // Collision arithmetic is done one bit wider so sums never wrap.
    localparam int XEW = XW + 1;
    localparam int YEW = YW + 1;
    localparam int CW  = $clog2(SERVE_FRAMES + 1);

    localparam logic [XW-1:0]  X_CTR    = XW'((H_RES - BALL_SZ) / 2);
    localparam logic [YW-1:0]  Y_CTR    = YW'((V_RES - BALL_SZ) / 2);
    localparam logic [XW-1:0]  X_STEP   = XW'(BALL_STEP);
    localparam logic [YW-1:0]  Y_STEP   = YW'(BALL_STEP);
    localparam logic [YW-1:0]  Y_MAX    = YW'(V_RES - BALL_SZ);
    localparam logic [XW-1:0]  X_FACE_L = XW'(PAD_X_L + PAD_W);
    localparam logic [XW-1:0]  X_FACE_R = XW'(PAD_X_R - BALL_SZ);
    localparam logic [XEW-1:0] XE_STEP  = XEW'(BALL_STEP);
    localparam logic [XEW-1:0] XE_MAX   = XEW'(H_RES - BALL_SZ);
    localparam logic [XEW-1:0] XE_FL    = XEW'(PAD_X_L + PAD_W);
    localparam logic [XEW-1:0] XE_FR    = XEW'(PAD_X_R - BALL_SZ);
    localparam logic [YEW-1:0] YE_STEP  = YEW'(BALL_STEP);
    localparam logic [YEW-1:0] YE_MAX   = YEW'(V_RES - BALL_SZ);
    localparam logic [YEW-1:0] YE_BALL  = YEW'(BALL_SZ);
    localparam logic [YEW-1:0] YE_PADH  = YEW'(PAD_H);
    localparam logic [CW-1:0]  SERVE_LAST = CW'(SERVE_FRAMES - 1);
    localparam logic [3:0]     WIN      = 4'(WIN_SCORE);

    state_t        r_state, w_state_next;
    logic [XW-1:0] r_x, w_x_next;
    logic [YW-1:0] r_y, w_y_next;
    logic          r_dir_x, w_dir_x_next;
    logic          r_dir_y, w_dir_y_next;
    logic [3:0]    r_score_l, w_score_l_next;
    logic [3:0]    r_score_r, w_score_r_next;
    logic [CW-1:0] r_serve_cnt, w_serve_cnt_next;
    logic          r_conceded_r, w_conceded_r_next;  // 1: right player missed last
    logic          r_start_pend;
    logic          r_hit, w_hit;

    logic [YW-1:0]  w_pad_l_y, w_pad_r_y;
    logic [XEW-1:0] w_xe;
    logic [YEW-1:0] w_ye, w_pl, w_pr;
    logic           w_ov_l, w_ov_r, w_hit_l, w_hit_r;
    logic           w_freeze, w_restart;

    assign w_freeze  = (r_state == ST_GAMEOVER);
    assign w_restart = w_freeze && r_start_pend;

    pong_paddle #(.YW(YW), .V_RES(V_RES), .PAD_H(PAD_H), .PAD_STEP(PAD_STEP)) u_pad_l (
        .i_clk(clk50), .i_rst(reset), .i_tick(frame_tick), .i_freeze(w_freeze),
        .i_recentre(w_restart), .i_up(l_up), .i_dn(l_dn), .o_y(w_pad_l_y)
    );

    pong_paddle #(.YW(YW), .V_RES(V_RES), .PAD_H(PAD_H), .PAD_STEP(PAD_STEP)) u_pad_r (
        .i_clk(clk50), .i_rst(reset), .i_tick(frame_tick), .i_freeze(w_freeze),
        .i_recentre(w_restart), .i_up(r_up), .i_dn(r_dn), .o_y(w_pad_r_y)
    );

    // Paddle overlap and face-crossing tests use pre-tick ball and paddles.
    assign w_xe    = {1'b0, r_x};
    assign w_ye    = {1'b0, r_y};
    assign w_pl    = {1'b0, w_pad_l_y};
    assign w_pr    = {1'b0, w_pad_r_y};
    assign w_ov_l  = (w_ye + YE_BALL > w_pl) && (w_ye < w_pl + YE_PADH);
    assign w_ov_r  = (w_ye + YE_BALL > w_pr) && (w_ye < w_pr + YE_PADH);
    assign w_hit_l = (w_xe >= XE_FL) && (w_xe < XE_FL + XE_STEP) && w_ov_l;
    assign w_hit_r = (w_xe <= XE_FR) && (w_xe + XE_STEP > XE_FR) && w_ov_r;

    // Next-state and datapath: nothing moves unless frame_tick is high.
    always_comb begin
        w_state_next      = r_state;
        w_x_next          = r_x;
        w_y_next          = r_y;
        w_dir_x_next      = r_dir_x;
        w_dir_y_next      = r_dir_y;
        w_score_l_next    = r_score_l;
        w_score_r_next    = r_score_r;
        w_serve_cnt_next  = r_serve_cnt;
        w_conceded_r_next = r_conceded_r;
        w_hit             = 1'b0;
        if (frame_tick) begin
            case (r_state)
                ST_SERVE: begin
                    if (r_serve_cnt == SERVE_LAST) begin
                        w_state_next     = ST_PLAY;
                        w_serve_cnt_next = '0;
                    end else begin
                        w_serve_cnt_next = r_serve_cnt + CW'(1);
                    end
                end
                ST_PLAY: begin
                    // Vertical motion with wall clamp and bounce.
                    if (r_dir_y == DIR_DOWN) begin
                        if (w_ye + YE_STEP >= YE_MAX) begin
                            w_y_next     = Y_MAX;
                            w_dir_y_next = DIR_UP;
                        end else begin
                            w_y_next = r_y + Y_STEP;
                        end
                    end else begin
                        if (r_y <= Y_STEP) begin
                            w_y_next     = '0;
                            w_dir_y_next = DIR_DOWN;
                        end else begin
                            w_y_next = r_y - Y_STEP;
                        end
                    end
                    // Horizontal motion: paddle hit, miss, or plain step.
                    if (r_dir_x == DIR_LEFT) begin
                        if (w_hit_l) begin
                            w_x_next     = X_FACE_L;
                            w_dir_x_next = DIR_RIGHT;
                            w_hit        = 1'b1;
                        end else if (w_xe < XE_STEP) begin
                            w_score_r_next    = sat_inc(r_score_r, WIN);
                            w_conceded_r_next = 1'b0;
                            w_state_next      = ST_SCORED;
                        end else begin
                            w_x_next = r_x - X_STEP;
                        end
                    end else begin
                        if (w_hit_r) begin
                            w_x_next     = X_FACE_R;
                            w_dir_x_next = DIR_LEFT;
                            w_hit        = 1'b1;
                        end else if (w_xe + XE_STEP > XE_MAX) begin
                            w_score_l_next    = sat_inc(r_score_l, WIN);
                            w_conceded_r_next = 1'b1;
                            w_state_next      = ST_SCORED;
                        end else begin
                            w_x_next = r_x + X_STEP;
                        end
                    end
                end
                ST_SCORED: begin
                    w_x_next     = X_CTR;
                    w_y_next     = Y_CTR;
                    w_dir_x_next = r_conceded_r ? DIR_RIGHT : DIR_LEFT;
                    w_state_next = (((r_conceded_r ? r_score_l : r_score_r) == WIN)
                                    ? ST_GAMEOVER : ST_SERVE);
                end
                ST_GAMEOVER: begin
                    if (r_start_pend) begin
                        w_score_l_next   = '0;
                        w_score_r_next   = '0;
                        w_x_next         = X_CTR;
                        w_y_next         = Y_CTR;
                        w_serve_cnt_next = '0;
                        w_state_next     = ST_SERVE;
                    end
                end
                default: ;
            endcase
        end
    end

    // State and datapath registers; start is remembered until the next tick.
    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            r_state      <= ST_SERVE;
            r_x          <= X_CTR;
            r_y          <= Y_CTR;
            r_dir_x      <= DIR_RIGHT;
            r_dir_y      <= DIR_DOWN;
            r_score_l    <= '0;
            r_score_r    <= '0;
            r_serve_cnt  <= '0;
            r_conceded_r <= 1'b0;
            r_start_pend <= 1'b0;
            r_hit        <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_x          <= w_x_next;
            r_y          <= w_y_next;
            r_dir_x      <= w_dir_x_next;
            r_dir_y      <= w_dir_y_next;
            r_score_l    <= w_score_l_next;
            r_score_r    <= w_score_r_next;
            r_serve_cnt  <= w_serve_cnt_next;
            r_conceded_r <= w_conceded_r_next;
            r_start_pend <= frame_tick ? start : (r_start_pend | start);
            r_hit        <= w_hit;
        end
    end

    assign ball_x    = r_x;
    assign ball_y    = r_y;
    assign pad_l_y   = w_pad_l_y;
    assign pad_r_y   = w_pad_r_y;
    assign score_l   = r_score_l;
    assign score_r   = r_score_r;
    assign state     = r_state;
    assign game_over = (r_state == ST_GAMEOVER);
    assign hit_pulse = r_hit;

endmodule

// File: tb/tb_pong_field_engine.sv
// Directed table-driven bench for pong_field_engine with hand-computed
// expectations, plus short hand sequences for multi-cycle corner cases.
module tb_pong_field_engine;

    logic       clk50 = 1'b0;
    logic       reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic       start = 1'b0;
    logic       l_up = 1'b0, l_dn = 1'b0, r_up = 1'b0, r_dn = 1'b0;
    logic [9:0] ball_x, ball_y, pad_l_y, pad_r_y;
    logic [3:0] score_l, score_r;
    logic [1:0] state;
    logic       game_over, hit_pulse;

    int n_checks = 0;
    int n_fail   = 0;

    pong_field_engine dut (
        .clk50(clk50), .reset(reset), .frame_tick(frame_tick), .start(start),
        .l_up(l_up), .l_dn(l_dn), .r_up(r_up), .r_dn(r_dn),
        .ball_x(ball_x), .ball_y(ball_y), .pad_l_y(pad_l_y), .pad_r_y(pad_r_y),
        .score_l(score_l), .score_r(score_r), .state(state),
        .game_over(game_over), .hit_pulse(hit_pulse)
    );

    always #10 clk50 = ~clk50;

    // One row: optional reset, optional start pulse, then N ticks with the
    // given buttons {l_up,l_dn,r_up,r_dn}, then expected outputs.
    typedef struct {
        bit       rst;
        bit       stp;
        int       ticks;
        bit [3:0] btn;
        int       st, bx, by, pl, pr, sl, sr;
        bit       hit;
    } vec_t;

    vec_t vecs[30];

    task automatic chk(input string nm, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
        end
    endtask

    task automatic chk_all(input string tag, input vec_t v);
        chk({tag, ".state"},     int'(state),     v.st);
        chk({tag, ".ball_x"},    int'(ball_x),    v.bx);
        chk({tag, ".ball_y"},    int'(ball_y),    v.by);
        chk({tag, ".pad_l_y"},   int'(pad_l_y),   v.pl);
        chk({tag, ".pad_r_y"},   int'(pad_r_y),   v.pr);
        chk({tag, ".score_l"},   int'(score_l),   v.sl);
        chk({tag, ".score_r"},   int'(score_r),   v.sr);
        chk({tag, ".game_over"}, int'(game_over), (v.st == 3) ? 1 : 0);
        chk({tag, ".hit_pulse"}, int'(hit_pulse), int'(v.hit));
    endtask

    // One-cycle tick; returns at the falling edge after the tick edge.
    task automatic tick();
        @(negedge clk50);
        frame_tick = 1'b1;
        @(negedge clk50);
        frame_tick = 1'b0;
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        v = vecs[i];
        if (v.rst) begin
            @(negedge clk50);
            reset = 1'b1;
            @(negedge clk50);
            reset = 1'b0;
        end
        if (v.stp) begin
            @(negedge clk50);
            start = 1'b1;
            @(negedge clk50);
            start = 1'b0;
        end
        {l_up, l_dn, r_up, r_dn} = v.btn;
        for (int t = 0; t < v.ticks; t++) tick();
        chk_all($sformatf("v%0d", i), v);
        $display("vec %0d: state=%0d ball=(%0d,%0d) pads=%0d/%0d score=%0d:%0d hit=%0d",
                 i, state, ball_x, ball_y, pad_l_y, pad_r_y, score_l, score_r, hit_pulse);
    endtask

    vec_t rst_v;

    initial begin
        // Segment A: serve timing, paddle limits, bottom wall, right hit.
        vecs[0]  = '{1, 0,   0, 4'b0000, 0, 315, 235, 200, 200, 0, 0, 0};
        vecs[1]  = '{0, 0,  50, 4'b1001, 0, 315, 235,   0, 400, 0, 0, 0};
        vecs[2]  = '{0, 0,   9, 4'b1001, 0, 315, 235,   0, 400, 0, 0, 0};
        vecs[3]  = '{0, 0,   1, 4'b1001, 1, 315, 235,   0, 400, 0, 0, 0};
        vecs[4]  = '{0, 0,   1, 4'b1111, 1, 317, 237,   0, 400, 0, 0, 0};
        vecs[5]  = '{0, 0, 116, 4'b0000, 1, 549, 469,   0, 400, 0, 0, 0};
        vecs[6]  = '{0, 0,   1, 4'b0000, 1, 551, 470,   0, 400, 0, 0, 0};
        vecs[7]  = '{0, 0,   1, 4'b0000, 1, 553, 468,   0, 400, 0, 0, 0};
        vecs[8]  = '{0, 0,  25, 4'b0000, 1, 603, 418,   0, 400, 0, 0, 0};
        vecs[9]  = '{0, 0,   1, 4'b0000, 1, 604, 416,   0, 400, 0, 0, 1};
        vecs[10] = '{0, 0,   1, 4'b0000, 1, 602, 414,   0, 400, 0, 0, 0};
        // Segment B: right misses until left wins, freeze, restart.
        vecs[11] = '{1, 0,  50, 4'b0010, 0, 315, 235, 200,   0, 0, 0, 0};
        vecs[12] = '{0, 0,  10, 4'b0010, 1, 315, 235, 200,   0, 0, 0, 0};
        vecs[13] = '{0, 0, 157, 4'b0010, 1, 629, 392, 200,   0, 0, 0, 0};
        vecs[14] = '{0, 0,   1, 4'b0010, 2, 629, 390, 200,   0, 1, 0, 0};
        vecs[15] = '{0, 0,   1, 4'b0010, 0, 315, 235, 200,   0, 1, 0, 0};
        // Rounds alternate the ball's vertical direction, so the right
        // paddle is parked at the opposite end each round to force a miss.
        for (int r = 2; r <= 8; r++) begin
            vecs[14 + r] = '{0, 0, 219, (r % 2 == 0) ? 4'b0001 : 4'b0010,
                             0, 315, 235, 200, (r % 2 == 0) ? 400 : 0, r, 0, 0};
        end
        vecs[23] = '{0, 1, 219, 4'b0010, 3, 315, 235, 200,   0, 9, 0, 0};
        vecs[24] = '{0, 0,  10, 4'b1001, 3, 315, 235, 200,   0, 9, 0, 0};
        vecs[25] = '{0, 1,   1, 4'b0000, 0, 315, 235, 200, 200, 0, 0, 0};
        vecs[26] = '{0, 0,  61, 4'b0000, 1, 317, 233, 200, 200, 0, 0, 0};
        // After the mid-play reset: serve timing and directions start over.
        vecs[27] = '{0, 0,  59, 4'b0000, 0, 315, 235, 200, 200, 0, 0, 0};
        vecs[28] = '{0, 0,   1, 4'b0000, 1, 315, 235, 200, 200, 0, 0, 0};
        vecs[29] = '{0, 0,   1, 4'b0000, 1, 317, 237, 200, 200, 0, 0, 0};

        for (int i = 0; i <= 9; i++) run_vec(i);

        // hit_pulse must drop on the very next cycle, ball untouched.
        @(negedge clk50);
        chk("hit_low_next_cycle", int'(hit_pulse), 0);
        chk("hit_ball_held", int'(ball_x), 604);
        $display("hand: cycle after hit hit_pulse=%0d ball_x=%0d", hit_pulse, ball_x);

        for (int i = 10; i <= 26; i++) run_vec(i);

        // Reset in the middle of play acts without a tick.
        @(negedge clk50);
        reset = 1'b1;
        #2;
        rst_v = '{0, 0, 0, 4'b0000, 0, 315, 235, 200, 200, 0, 0, 0};
        chk_all("midplay_reset", rst_v);
        $display("hand: mid-play reset state=%0d ball=(%0d,%0d)", state, ball_x, ball_y);
        @(negedge clk50);
        reset = 1'b0;

        for (int i = 27; i <= 29; i++) run_vec(i);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
